// File: rtl/demux8_buf.sv
// rtl/demux8_buf.sv - buffered 1-to-8 steering demultiplexer with 2-entry in-order FIFO
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      active-low synchronous reset
//   flush      synchronous clear of buffered entries (entry contents retained)
//   in_valid   upstream word valid
//   in_ready   buffer can accept a word (registered state only)
//   in_data    upstream word, WIDTH bits
//   in_sel     destination port index 0..7, sampled on push
//   out_valid  one-hot, bit i = head entry targets port i
//   out_ready  per-port consumer ready, only the head's port is honoured
//   out_data   head entry data, shared by all ports
//   busy       FIFO non-empty
//   cnt_sel    (DEMUX8_CNT_EN) counter select
//   cnt_val    (DEMUX8_CNT_EN) delivery count of port cnt_sel
//
// Optional feature macro: DEMUX8_CNT_EN adds eight 32-bit per-port delivery
// counters that clear on reset only.

module demux8_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef DEMUX8_CNT_EN
    ,
    input  logic [2:0]       cnt_sel,
    output logic [31:0]      cnt_val
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // Two entries addressed by single-bit pointers; DEPTH is fixed at 2.
    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [2:0]       mem_sel  [DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;

    logic             head_valid;
    logic [2:0]       hsel;
    logic             push;
    logic             pop;

    // Handshakes. Flush wins over both, so neither pointer nor counter moves.
    always_comb begin
        hsel       = mem_sel[rd_ptr];
        head_valid = (state_q != EMPTY);
        in_ready   = (state_q != FULL);
        busy       = head_valid;
        out_data   = mem_data[rd_ptr];
        out_valid  = head_valid ? (8'b1 << hsel) : 8'h00;
        push       = in_valid && in_ready && !flush;
        pop        = head_valid && out_ready[hsel] && !flush;
    end

    // Occupancy FSM next state.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop)      state_d = FULL;
                    else if (pop && !push) state_d = EMPTY;
                end
                FULL:    if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers and storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_sel[i]  <= 3'd0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= in_data;
                mem_sel[wr_ptr]  <= in_sel;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

`ifdef DEMUX8_CNT_EN
    logic [31:0] cnt [8];

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= 32'd0;
            end
        end else if (pop) begin
            cnt[hsel] <= cnt[hsel] + 32'd1;
        end
    end

    assign cnt_val = cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_demux8_buf.sv
// tb/tb_demux8_buf.sv - self-checking bench for demux8_buf

module tb_demux8_buf;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [2:0]  in_sel;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [63:0] out_data;
    logic        busy;
`ifdef DEMUX8_CNT_EN
    logic [2:0]  cnt_sel;
    logic [31:0] cnt_val;
`endif

    demux8_buf #(.WIDTH(64), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef DEMUX8_CNT_EN
        ,
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  s;
    } ent_t;

    ent_t        q[$];
    int unsigned mcnt [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of at most two words, updated from the inputs
    // that were stable at the edge.
    always @(posedge clk) begin
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (!reset) begin
            q.delete();
            for (int i = 0; i < 8; i++) mcnt[i] = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            do_pop  = (q.size() > 0) && out_ready[q[0].s];
            do_push = in_valid && (q.size() < 2);
            if (do_pop) begin
                mcnt[q[0].s] = mcnt[q[0].s] + 1;
                void'(q.pop_front());
            end
            if (do_push) begin
                e.d = in_data;
                e.s = in_sel;
                q.push_back(e);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
                chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
                chk("out_valid", {56'd0, out_valid},
                    (q.size() != 0) ? {56'd0, 8'b1 << q[0].s} : 64'd0);
                if (q.size() != 0) chk("out_data", out_data, q[0].d);
`ifdef DEMUX8_CNT_EN
                chk("cnt_val", {32'd0, cnt_val}, {32'd0, mcnt[cnt_sel]});
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] d, input logic [2:0] s);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 3'd0;
        out_ready = 8'hFF;
`ifdef DEMUX8_CNT_EN
        cnt_sel   = 3'd0;
`endif
        step();
        step();
        reset  = 1'b1;
        chk_en = 1'b1;

        // Reset state
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {56'd0, out_valid}, 64'h00);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // Single word to port 5, consumed the cycle it appears
        push_word(64'hDEAD_BEEF_0000_0001, 3'd5);
        chk("t1_out_valid", {56'd0, out_valid}, 64'h20);
        chk("t1_out_data", out_data, 64'hDEAD_BEEF_0000_0001);
        step();
        chk("t1_busy_after", {63'd0, busy}, 64'd0);

        // Head-of-line blocking
        out_ready = 8'h00;
        push_word(64'h0000_0000_0000_0A02, 3'd2);
        push_word(64'h0000_0000_0000_0B07, 3'd7);
        chk("hol_in_ready_full", {63'd0, in_ready}, 64'd0);
        out_ready = 8'h80;
        step();
        step();
        chk("hol_blocked", {56'd0, out_valid}, 64'h04);
        chk("hol_data", out_data, 64'h0000_0000_0000_0A02);
        out_ready = 8'h04;
        step();
        chk("hol_next", {56'd0, out_valid}, 64'h80);
        chk("hol_next_data", out_data, 64'h0000_0000_0000_0B07);
        out_ready = 8'hFF;
        step();
        chk("hol_drained", {63'd0, busy}, 64'd0);

        // Sustained streaming, one word per cycle
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 64'h5100_0000_0000_0000 | 64'(i);
            in_sel  = 3'(i % 8);
            step();
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            chk("stream_out_valid", {56'd0, out_valid}, {56'd0, 8'b1 << (i % 8)});
        end
        in_valid = 1'b0;
        step();
        step();

        // Flush while FULL with a simultaneous push attempt
        out_ready = 8'h00;
        push_word(64'h1111, 3'd1);
        push_word(64'h2222, 3'd3);
        in_valid = 1'b1;
        in_data  = 64'h3333;
        in_sel   = 3'd6;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {56'd0, out_valid}, 64'h00);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        out_ready = 8'hFF;
        for (int i = 0; i < 3; i++) step();

        // Reset while FULL and stalled
        out_ready = 8'h00;
        push_word(64'h4444, 3'd4);
        push_word(64'h5555, 3'd5);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst2_out_valid", {56'd0, out_valid}, 64'h00);
        chk("rst2_out_data", out_data, 64'd0);
        chk("rst2_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 8'hFF;
        step();

`ifdef DEMUX8_CNT_EN
        // Per-port delivery counters
        push_word(64'hC0, 3'd4);
        push_word(64'hC1, 3'd4);
        push_word(64'hC2, 3'd0);
        push_word(64'hC3, 3'd4);
        step();
        step();
        cnt_sel = 3'd4;
        #1;
        chk("cnt4", {32'd0, cnt_val}, 64'd3);
        cnt_sel = 3'd0;
        #1;
        chk("cnt0", {32'd0, cnt_val}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("cnt0_after_flush", {32'd0, cnt_val}, 64'd1);
        cnt_sel = 3'd4;
        #1;
        chk("cnt4_after_flush", {32'd0, cnt_val}, 64'd3);
        step();
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux8_buf.md
Name: demux8_buf

Overview:
- Buffered 1-to-8 steering demultiplexer; the distribution counterpart of the 8-way result select.
- Takes one 64-bit word plus a 3-bit destination index on a valid/ready input channel.
- Delivers the word to exactly one of eight valid/ready output channels.
- Internal 2-entry in-order FIFO registers the path: in_ready never depends combinationally on out_ready.
- Used between a single producer (e.g. writeback/forwarding source) and up to eight consumers.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 2, FIFO entries; fixed at 2, any other value is unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  active-low synchronous reset.
- flush  input  1  synchronous clear of buffered entries.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- in_sel  input  3  destination port index 0..7.
- out_valid  output  8  one-hot; bit i = head entry targets port i.
- out_ready  input  8  per-port consumer ready.
- out_data  output  WIDTH  head entry data, shared by all ports.
- busy  output  1  FIFO non-empty.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a clk edge):
  - count=0, rd_ptr=wr_ptr=0, all entry data/sel cleared to 0.
  - Outputs after reset: in_ready=1, out_valid=8'h00, out_data=0, busy=0.
  - Reset mid-transfer discards all buffered words silently.
- States by count: EMPTY(0), ONE(1), FULL(2). in_ready = (count!=2), derived from registered state only.
- Push: in_valid && in_ready. Word and sel written at wr_ptr; wr_ptr wraps 1->0.
- Head: out_data = entry[rd_ptr].data; out_valid = (count!=0) ? (8'b1 << entry[rd_ptr].sel) : 0.
- Pop: out_valid[hsel] && out_ready[hsel]. rd_ptr wraps 1->0. out_ready bits of non-selected ports are ignored.
- Transitions:
  - EMPTY --push--> ONE.
  - ONE --push&&!pop--> FULL; ONE --pop&&!push--> EMPTY; ONE --push&&pop--> ONE.
  - FULL --pop--> ONE. No push possible in FULL.
- Latency: word accepted at edge N is visible on outputs after edge N (one-cycle latency). No bypass from in to out while EMPTY.
- Throughput: one word per cycle sustained when the head consumer is always ready.
- Ordering:
  - Strict in-order delivery across all ports.
  - A stalled head blocks later words to other ports (head-of-line blocking is intended).
- out_data holds its value while out_valid is asserted and unpopped; out_valid never drops without a pop, flush or reset.
- Flush (flush==1, reset==1):
  - count=0, pointers=0, entry contents retained but invalid.
  - Priority over simultaneous push/pop: the push is dropped and in_ready remains per the pre-flush state that cycle.
- in_sel is sampled only on push; all 8 encodings are legal, so no error path exists.

Optional Feature:
- Macro: DEMUX8_CNT_EN.
- Defined:
  - Adds ports cnt_sel input 3 and cnt_val output 32.
  - Eight 32-bit per-port delivery counters increment on each pop to that port and wrap 0xFFFFFFFF->0.
  - Counters clear on reset only, not on flush.
  - cnt_val = counter[cnt_sel] combinationally.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with out_ready=8'hFF, then push data=64'hDEAD_BEEF_0000_0001 sel=5 -> next cycle out_valid=8'h20, out_data matches, popped same cycle, busy=0 after.
- Out_ready=0, push sel=2 then sel=7 -> in_ready=0 after the second push. Raise out_ready[7] only -> no pop (HOL). Raise out_ready[2] -> pop, then out_valid=8'h80.
- Stream 16 words, sels 0..7 twice, out_ready=8'hFF, in_valid held -> one word per cycle, each on out_valid=1<<sel, order preserved, in_ready stays 1.
- FULL with push attempt plus flush=1 in the same cycle -> next cycle count=0, out_valid=0, in_ready=1; the dropped word never appears.
- Assert reset=0 while FULL and stalled -> next cycle out_valid=0, out_data=0, in_ready=1.
- With DEMUX8_CNT_EN: deliver 3 words to port 4 and 1 to port 0 -> cnt_sel=4 gives cnt_val=3, cnt_sel=0 gives 1. A flush leaves the values unchanged.
